// File: rtl/elastic_pipe_chain.sv
// Elastic DEPTH-stage valid/ready register chain. Ready ripples backward combinationally,
// so bubbles collapse and an unstalled chain streams one word per cycle.
module elastic_pipe_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_reg;
  logic [DEPTH-1:0] v_next;
  logic [WIDTH-1:0] d_reg [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;

  // Walk from the output side so each stage sees whether its successor is emptying.
  always_comb begin
    adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i == DEPTH - 1)
        adv[i] = v_reg[i] & out_ready & ~flush;
      else
        adv[i] = v_reg[i] & (~v_reg[i+1] | adv[i+1]) & ~flush;
    end
  end

  assign in_ready  = (~v_reg[0] | adv[0]) & ~flush;
  assign out_valid = v_reg[DEPTH-1] & ~flush;
  assign out_data  = d_reg[DEPTH-1];
  assign count     = count_reg;

  always_comb begin
    v_next     = v_reg;
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush)
        v_next[i] = 1'b0;
      else if (load[i])
        v_next[i] = 1'b1;
      else if (adv[i])
        v_next[i] = 1'b0;
      count_next = count_next + CW'(v_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg     <= '0;
      count_reg <= '0;
    end else begin
      v_reg     <= v_next;
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] d_src;
      if (gi == 0) begin : g_head
        assign load[gi] = in_valid & in_ready;
        assign d_src    = in_data;
      end else begin : g_body
        assign load[gi] = adv[gi-1];
        assign d_src    = d_reg[gi-1];
      end

      // Data only moves on an accepted transfer, so an invalid in_data never enters.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          d_reg[gi] <= RESET_DATA;
        else if (load[gi])
          d_reg[gi] <= d_src;
      end
    end
  endgenerate

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Directed bench for elastic_pipe_chain (WIDTH=8, DEPTH=3): vector table plus
// hand-written reset and latency sequences.
module tb_elastic_pipe_chain;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  elastic_pipe_chain #(.WIDTH(8), .DEPTH(3), .RESET_DATA(8'h00)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = clk_en ? ~clk : clk;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic ir, input logic ov,
                         input logic [7:0] od, input logic [1:0] cnt, input logic chk_od);
    chk({tag, ".in_ready"}, idx, 32'(in_ready), 32'(ir));
    chk({tag, ".out_valid"}, idx, 32'(out_valid), 32'(ov));
    chk({tag, ".count"}, idx, 32'(count), 32'(cnt));
    if (chk_od) chk({tag, ".out_data"}, idx, 32'(out_data), 32'(od));
    $display("%s step %0d: in_ready=%0b out_valid=%0b out_data=%02h count=%0d",
             tag, idx, in_ready, out_valid, out_data, count);
  endtask

  initial begin
    //              fl iv id     ordy ir ov od     cnt
    vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1};
    vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2'd3};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[7]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[8]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
    vecs[9]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2};
    vecs[10] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3};
    vecs[11] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h11, 2'd3};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 2'd3};
    vecs[13] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 2'd3};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[16] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
    vecs[18] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd2};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd2};
    vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd2};
    vecs[22] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 2'd1};
    vecs[23] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};

    // Reset with the clock stopped.
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #2;
    chk_all("reset", 0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);
    rst = 1'b0;
    #1 clk_en = 1'b1;

    // Table: drive at negedge, check combinational view, the next posedge commits.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      flush = vecs[i].fl; in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
      #1;
      chk_all("vec", i, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_cnt, vecs[i].e_ov);
    end

    // Stream 0x01.. then pulse rst between edges.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b1; in_data = 8'(k); out_ready = 1'b1;
    end
    @(negedge clk);
    in_data = 8'h04;
    #1;
    chk_all("stream", 0, 1'b1, 1'b1, 8'h01, 2'd3, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);
    rst = 1'b0; in_valid = 1'b0;

    // First word after release needs the full three-stage latency.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h10;
    #1;
    chk_all("latency", 0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_all("latency", 1, 1'b1, 1'b0, 8'h00, 2'd1, 1'b0);
    @(negedge clk);
    #1;
    chk_all("latency", 2, 1'b1, 1'b0, 8'h00, 2'd1, 1'b0);
    @(negedge clk);
    #1;
    chk_all("latency", 3, 1'b1, 1'b1, 8'h10, 2'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
